// File: rtl/jt51_lfo_ctrl.sv
// LFO register front-end for the JT51: decodes CPU writes and queues LFO settings in a 2-entry FIFO.
// Each queued setting commits on a cen&zero frame boundary. JT51_LFO_WAVE_RST_EN enables the LFO reset that follows a waveform change.
module jt51_lfo_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       zero,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       ovf,
    output logic       lfo_rst,
    output logic [7:0] lfo_freq,
    output logic [6:0] lfo_amd,
    output logic [6:0] lfo_pmd,
    output logic [1:0] lfo_w
);

    typedef enum logic [1:0] {TGT_FREQ, TGT_AMD, TGT_PMD, TGT_W} tgt_e;
    typedef struct packed {
        tgt_e       tgt;
        logic [7:0] data;
    } entry_t;
    typedef enum logic {IDLE, WRST} state_e;

    entry_t     fifo [2];
    entry_t     wr_entry;
    entry_t     head;
    logic       wr_ptr, rd_ptr;
    logic [1:0] count, count_nxt;
    logic       is_queued, push, drop, pop;
    logic       test_bit;
    logic       wave_rst_req;
    state_e     state, state_nxt;
    logic [1:0] pulse_cnt, pulse_cnt_nxt;

    always_comb begin
        is_queued    = 1'b0;
        wr_entry.tgt = TGT_FREQ;
        wr_entry.data = wr_data;
        case (wr_addr)
            8'h18: is_queued = 1'b1;
            8'h19: begin
                is_queued    = 1'b1;
                wr_entry.tgt = wr_data[7] ? TGT_PMD : TGT_AMD;
            end
            8'h1B: begin
                is_queued    = 1'b1;
                wr_entry.tgt = TGT_W;
            end
            default: ;
        endcase
    end

    // busy blocks the push even when a pop frees a slot on the same cycle.
    assign push      = wr_en & is_queued & ~busy;
    assign drop      = wr_en & is_queued & busy;
    assign pop       = (state == IDLE) & cen & zero & (count != 2'd0);
    assign head      = fifo[rd_ptr];
    assign count_nxt = count + {1'b0, push} - {1'b0, pop};

    // NOTE: FIFO storage has no reset; count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            count    <= 2'd0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            test_bit <= 1'b0;
            lfo_freq <= 8'd0;
            lfo_amd  <= 7'd0;
            lfo_pmd  <= 7'd0;
            lfo_w    <= 2'd0;
        end else begin
            count <= count_nxt;
            busy  <= (count_nxt == 2'd2);
            if (drop) ovf <= 1'b1;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            if (wr_en && wr_addr == 8'h01) test_bit <= wr_data[1];
            if (pop) begin
                case (head.tgt)
                    TGT_FREQ: lfo_freq <= head.data;
                    TGT_AMD:  lfo_amd  <= head.data[6:0];
                    TGT_PMD:  lfo_pmd  <= head.data[6:0];
                    TGT_W:    lfo_w    <= head.data[1:0];
                endcase
            end
        end
    end

`ifdef JT51_LFO_WAVE_RST_EN
    assign wave_rst_req = pop && (head.tgt == TGT_W) && (head.data[1:0] != lfo_w);
`else
    assign wave_rst_req = 1'b0;
`endif

    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pulse_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            pulse_cnt <= pulse_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pulse_cnt_nxt = pulse_cnt;
        case (state)
            IDLE: if (wave_rst_req) begin
                state_nxt     = WRST;
                pulse_cnt_nxt = 2'd2;
            end
            WRST: if (cen) begin
                pulse_cnt_nxt = pulse_cnt - 2'd1;
                if (pulse_cnt == 2'd1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign lfo_rst = test_bit | (state == WRST);

endmodule

// File: tb/tb_jt51_lfo_ctrl.sv
// Directed bench for jt51_lfo_ctrl; expectations follow JT51_LFO_WAVE_RST_EN when the bench is built with it.
module tb_jt51_lfo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen, zero, wr_en;
    logic [7:0] wr_addr, wr_data;
    logic       busy, ovf, lfo_rst;
    logic [7:0] lfo_freq;
    logic [6:0] lfo_amd, lfo_pmd;
    logic [1:0] lfo_w;

    int checks = 0;
    int errors = 0;

    jt51_lfo_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .zero    (zero),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .ovf     (ovf),
        .lfo_rst (lfo_rst),
        .lfo_freq(lfo_freq),
        .lfo_amd (lfo_amd),
        .lfo_pmd (lfo_pmd),
        .lfo_w   (lfo_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic c, input logic z, input logic we,
                       input logic [7:0] a, input logic [7:0] d);
        cen = c; zero = z; wr_en = we; wr_addr = a; wr_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic frame();
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cyc(1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        rst = 1'b0;
        idle();
    endtask

    initial begin
        cen = 0; zero = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        rst = 1'b1;
        idle(); idle();
        rst = 1'b0;
        idle();

        // Reset state
        check("rst_freq", lfo_freq, 8'h00);
        check("rst_amd", {1'b0, lfo_amd}, 8'h00);
        check("rst_pmd", {1'b0, lfo_pmd}, 8'h00);
        check("rst_w", {6'b0, lfo_w}, 8'h00);
        check("rst_lfo_rst", {7'b0, lfo_rst}, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        check("rst_ovf", {7'b0, ovf}, 8'h00);

        // LFRQ waits for a cen&zero boundary
        wr(8'h18, 8'hA5);
        check("freq_queued_busy", {7'b0, busy}, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        check("freq_no_frame", lfo_freq, 8'h00);
        frame();
        check("freq_commit", lfo_freq, 8'hA5);
        frame();
        check("freq_empty_frame", lfo_freq, 8'hA5);

        // Overflow: third back-to-back write dropped
        do_reset();
        wr(8'h19, 8'h85);
        check("ovf_busy_after1", {7'b0, busy}, 8'h00);
        wr(8'h19, 8'h20);
        check("ovf_busy_after2", {7'b0, busy}, 8'h01);
        wr(8'h18, 8'h11);
        check("ovf_set", {7'b0, ovf}, 8'h01);
        frame();
        check("ovf_pmd", {1'b0, lfo_pmd}, 8'h05);
        check("ovf_amd_first", {1'b0, lfo_amd}, 8'h00);
        check("ovf_busy_after_pop", {7'b0, busy}, 8'h00);
        frame();
        check("ovf_amd", {1'b0, lfo_amd}, 8'h20);
        frame();
        check("ovf_freq_dropped", lfo_freq, 8'h00);
        check("ovf_sticky", {7'b0, ovf}, 8'h01);

        // Write while full dropped even with a pop on the same cycle
        do_reset();
        wr(8'h18, 8'h01);
        wr(8'h18, 8'h02);
        cyc(1'b1, 1'b1, 1'b1, 8'h18, 8'h03);
        check("drop_on_pop_ovf", {7'b0, ovf}, 8'h01);
        frame();
        check("drop_on_pop_freq2", lfo_freq, 8'h02);
        frame();
        check("drop_on_pop_freq_final", lfo_freq, 8'h02);

        // Unknown address while full: ignored, no ovf
        do_reset();
        wr(8'h19, 8'h81);
        wr(8'h18, 8'h77);
        wr(8'h20, 8'h55);
        check("other_addr_ovf", {7'b0, ovf}, 8'h00);
        check("other_addr_busy", {7'b0, busy}, 8'h01);

        // Reset with queued entries discards them
        rst = 1'b1;
        idle();
        rst = 1'b0;
        frame(); frame(); frame();
        check("rstq_freq", lfo_freq, 8'h00);
        check("rstq_amd", {1'b0, lfo_amd}, 8'h00);
        check("rstq_pmd", {1'b0, lfo_pmd}, 8'h00);
        check("rstq_busy", {7'b0, busy}, 8'h00);
        check("rstq_ovf", {7'b0, ovf}, 8'h00);

        // Test bit bypasses the queue
        wr(8'h01, 8'h02);
        check("test_bit_set", {7'b0, lfo_rst}, 8'h01);
        wr(8'h01, 8'hFD);
        check("test_bit_other_bits", {7'b0, lfo_rst}, 8'h00);
        wr(8'h01, 8'h02);
        wr(8'h01, 8'h00);
        check("test_bit_clr", {7'b0, lfo_rst}, 8'h00);

        // Push and pop together at count 1 keeps order
        wr(8'h19, 8'h81);
        cyc(1'b1, 1'b1, 1'b1, 8'h19, 8'h07);
        check("pushpop_pmd", {1'b0, lfo_pmd}, 8'h01);
        check("pushpop_busy", {7'b0, busy}, 8'h00);
        frame();
        check("pushpop_amd", {1'b0, lfo_amd}, 8'h07);

        // Waveform change
        do_reset();
        wr(8'h1B, 8'h02);
        wr(8'h18, 8'h33);
        frame();
        check("w_commit", {6'b0, lfo_w}, 8'h02);
`ifdef JT51_LFO_WAVE_RST_EN
        check("wrst_pulse0", {7'b0, lfo_rst}, 8'h01);
        frame();
        check("wrst_pulse1", {7'b0, lfo_rst}, 8'h01);
        check("wrst_no_pop1", lfo_freq, 8'h00);
        idle();
        check("wrst_hold_no_cen", {7'b0, lfo_rst}, 8'h01);
        frame();
        check("wrst_end", {7'b0, lfo_rst}, 8'h00);
        check("wrst_no_pop2", lfo_freq, 8'h00);
        frame();
        check("wrst_after_freq", lfo_freq, 8'h33);
`else
        check("w_no_wrst", {7'b0, lfo_rst}, 8'h00);
        frame();
        check("w_after_freq", lfo_freq, 8'h33);
`endif

        // Equal W rewrite uses a frame slot with no visible change
        wr(8'h1B, 8'h02);
        wr(8'h18, 8'h44);
        frame();
        check("eq_w_value", {6'b0, lfo_w}, 8'h02);
        check("eq_w_no_rst", {7'b0, lfo_rst}, 8'h00);
        check("eq_w_slot_used", lfo_freq, 8'h33);
        frame();
        check("eq_w_next", lfo_freq, 8'h44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jt51_lfo_ctrl.md
JT51_LFO_CTRL -- requirements
Module: jt51_lfo_ctrl

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cen  in  1  clock enable; all LFO-facing sequencing advances only on cen.
REQ-005 zero  in  1  sample-frame boundary strobe; meaningful only together with cen.
REQ-006 wr_en  in  1  CPU register write strobe.
REQ-007 wr_addr  in  8  YM2151 register address.
REQ-008 wr_data  in  8  register data.
REQ-009 busy  out  1  write queue full; a write while busy is dropped.
REQ-010 ovf  out  1  sticky flag: set when a queued-register write is dropped.
REQ-011 lfo_rst  out  1  LFO synchronous reset request.
REQ-012 lfo_freq  out  8  LFRQ.
REQ-013 lfo_amd  out  7  AM depth.
REQ-014 lfo_pmd  out  7  PM depth.
REQ-015 lfo_w  out  2  waveform select.

Function
REQ-016 Decode: 0x18 -> LFRQ; 0x19 with wr_data[7]=1 -> PMD=wr_data[6:0]; 0x19 with wr_data[7]=0 -> AMD=wr_data[6:0]; 0x1B -> W=wr_data[1:0]; 0x01 -> test bit wr_data[1]; any other address ignored (not queued, no ovf).
REQ-017 0x01 SHALL bypass the queue: the test bit register updates on the clk edge of the write, with or without cen.
REQ-018 0x18/0x19/0x1B writes SHALL enter a 2-entry FIFO (entry = 2-bit target id + 8-bit data) when busy=0.
REQ-019 busy SHALL equal (queue count == 2), registered; a write on a cycle with busy=1 is dropped and sets ovf, even if a pop occurs on that same cycle.
REQ-020 Simultaneous push and pop with count 1 SHALL leave count 1 and preserve FIFO order.
REQ-021 FSM states: IDLE, WRST. In IDLE, on a cycle with cen=1, zero=1 and count>0, the head entry SHALL be popped and applied; the corresponding output changes at that clk edge (visible the next cycle).
REQ-022 At most one entry SHALL be committed per cen&zero frame boundary.
REQ-023 Rewriting a target with an equal value SHALL still consume a frame slot but cause no output change.
REQ-024 lfo_rst SHALL equal test_bit OR wrst_active, from registers (no combinational path from wr_* inputs).
REQ-025 In WRST no pops SHALL occur; writes may still be queued.

Reset
REQ-026 On rst: lfo_freq=0, lfo_amd=0, lfo_pmd=0, lfo_w=0, test bit=0, lfo_rst=0, busy=0, ovf=0, queue empty, FSM=IDLE, pulse counter=0.
REQ-027 rst asserted mid-WRST or with queued entries SHALL discard all pending entries; nothing is committed after release until a new write and frame boundary.
REQ-028 ovf SHALL be cleared only by rst.

Configuration
REQ-029 Macro JT51_LFO_WAVE_RST_EN: when defined, committing a W value different from the current lfo_w SHALL update lfo_w and enter WRST, holding lfo_rst=1 for exactly 2 cen cycles (counter decrements only on cen), then return to IDLE; an equal W causes no WRST.
REQ-030 When JT51_LFO_WAVE_RST_EN is undefined, W commits like any other target; WRST is never entered and lfo_rst equals the test bit.

Verification
REQ-031 Write 0x18=0xA5, no cen&zero -> lfo_freq stays 0x00; first cen&zero -> lfo_freq=0xA5 next cycle.
REQ-032 Writes 0x19=0x85, 0x19=0x20, 0x18=0x11 back-to-back -> third dropped, busy=1 after second, ovf=1; two frames later lfo_pmd=0x05, lfo_amd=0x20, lfo_freq=0x00.
REQ-033 Macro defined, lfo_w=0, commit 0x1B=0x02 -> lfo_w=2, lfo_rst high for exactly 2 cen pulses; queued 0x18=0x33 commits at the first frame boundary after WRST ends.
REQ-034 Write 0x01=0x02 with cen=0 -> lfo_rst=1 next cycle; write 0x01=0x00 -> lfo_rst=0 next cycle.
REQ-035 Queue two entries, assert rst for 1 cycle, then 3 frame boundaries -> all outputs remain 0, busy=0, ovf=0.
REQ-036 Write to 0x20 while queue full -> ignored, ovf unchanged.
